// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a control unit and the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, result, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, result, c_out, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: one bit pair per clock through a
// single full adder cell, LSB first, carry kept in a register.
//
// state | meaning
// IDLE  | waiting for start; last result, c_out and ovf held
// RUN   | shifting one bit pair per clock through the full adder
// DONE  | one-cycle done pulse; start here is accepted back-to-back

module serial_add_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_co;

  serial_add_fa u_fa (
    .x  (sh_a[0]),
    .y  (sh_b[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sequencer: operand latch, serial shift, final carry/overflow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      res_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          carry_q <= fa_co;
          if (cnt == LAST) begin
            // carry_q here is the carry into the MSB, fa_co the carry out of it
            cout_q <= fa_co;
            ovf_q  <= carry_q ^ fa_co;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // subtraction is a + ~b + 1, so the carry-in is forced high
            sh_a    <= bus.a;
            sh_b    <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.c_in;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.c_out  = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH = 8.
module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   done_cnt;
  exp_t sb[$];

  serial_add_ctrl_if #(.WIDTH(W)) bus_i ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y0,
                                 input logic s, input logic ci);
    exp_t m;
    logic [W-1:0] y;
    logic [W:0]   t;
    y = s ? ~y0 : y0;
    t = {1'b0, x} + {1'b0, y} + (W+1)'(s | ci);
    m.res = t[W-1:0];
    m.co  = t[W];
    m.ov  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    m.cyc = 0;
    return m;
  endfunction

  // Monitor: every done pulse is checked against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus_i.done) begin
      done_cnt++;
      check_val("busy_with_done", 32'(bus_i.busy), 32'd0);
      if (sb.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("result", 32'(bus_i.result), 32'(e.res));
        check_val("c_out", 32'(bus_i.c_out), 32'(e.co));
        check_val("ovf", 32'(bus_i.ovf), 32'(e.ov));
        check_val("latency", 32'(cyc - e.cyc), 32'(W));
      end
    end
  end

  // Called at a negedge; returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tc, input bit push,
                          input exp_t e);
    exp_t ee;
    bus_i.a     = ta;
    bus_i.b     = tb_v;
    bus_i.sub   = ts;
    bus_i.c_in  = tc;
    bus_i.start = 1'b1;
    @(posedge clk);
    #1;
    bus_i.start = 1'b0;
    if (push) begin
      ee     = e;
      ee.cyc = cyc;
      sb.push_back(ee);
    end
  endtask

  task automatic start_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic ts, input logic tc,
                           input logic [W-1:0] er, input logic eco, input logic eov);
    exp_t e;
    e.res = er; e.co = eco; e.ov = eov; e.cyc = 0;
    start_op(ta, tb_v, ts, tc, 1'b1, e);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_i.done) seen = 1'b1;
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int   dc;
    exp_t m;
    logic [W-1:0] ra, rb;
    logic rs, rc;

    cyc = 0; checks = 0; errors = 0; done_cnt = 0;
    bus_i.start = 1'b0; bus_i.sub = 1'b0; bus_i.a = '0; bus_i.b = '0; bus_i.c_in = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(bus_i.busy), 32'd0);
    check_val("rst_done", 32'(bus_i.done), 32'd0);
    check_val("rst_result", 32'(bus_i.result), 32'd0);
    check_val("rst_c_out", 32'(bus_i.c_out), 32'd0);
    check_val("rst_ovf", 32'(bus_i.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // add with signed overflow
    start_exp(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    check_val("busy_after_start", 32'(bus_i.busy), 32'd1);
    check_val("done_after_start", 32'(bus_i.done), 32'd0);
    wait_done("add_ovf");
    @(negedge clk);
    check_val("hold_result", 32'(bus_i.result), 32'h96);
    check_val("hold_ovf", 32'(bus_i.ovf), 32'd1);
    check_val("idle_busy", 32'(bus_i.busy), 32'd0);
    check_val("idle_done", 32'(bus_i.done), 32'd0);

    // unsigned carry with carry-in
    start_exp(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    wait_done("add_cin");
    @(negedge clk);

    // subtract with borrow, then with signed overflow
    start_exp(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    wait_done("sub_borrow");
    @(negedge clk);
    start_exp(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    wait_done("sub_ovf");
    @(negedge clk);

    // start during RUN is ignored
    dc = done_cnt;
    start_exp(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    m = model(8'h77, 8'h77, 1'b0, 1'b0);
    start_op(8'h77, 8'h77, 1'b0, 1'b0, 1'b0, m);
    wait_done("run_start");
    repeat (12) @(negedge clk);
    check_val("run_start_done_cnt", 32'(done_cnt - dc), 32'd1);

    // back-to-back: start asserted in the DONE cycle
    start_exp(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    wait_done("b2b_first");
    start_exp(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    wait_done("b2b_second");
    @(negedge clk);

    // random operations against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      m  = model(ra, rb, rs, rc);
      start_op(ra, rb, rs, rc, 1'b1, m);
      wait_done("rand");
      if (i % 2 == 1) @(negedge clk);
    end
    @(negedge clk);

    // asynchronous reset mid-operation
    dc = done_cnt;
    m  = model(8'hAA, 8'h55, 1'b0, 1'b0);
    start_op(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, m);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", 32'(bus_i.busy), 32'd0);
    check_val("arst_done", 32'(bus_i.done), 32'd0);
    check_val("arst_result", 32'(bus_i.result), 32'd0);
    check_val("arst_c_out", 32'(bus_i.c_out), 32'd0);
    check_val("arst_ovf", 32'(bus_i.ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("arst_no_done", 32'(done_cnt - dc), 32'd0);
    start_exp(8'h21, 8'h43, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0);
    wait_done("after_rst");
    repeat (3) @(negedge clk);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
